// File: rtl/dequant_pkg.sv
// Shared parameters, row record type and the per-word dequantization helper
// for the 8-lane dequantizer.
package dequant_pkg;

  localparam int LANES = 8;
  localparam int IN_W  = 8;
  localparam int OUT_W = IN_W + 1;
  localparam int ROWS  = 8;
  localparam int ROW_W = $clog2(ROWS);

  typedef struct packed {
    logic [LANES-1:0][OUT_W-1:0] data;
    logic [ROW_W-1:0]            row;
  } row_rec_t;

  localparam int REC_W = $bits(row_rec_t);

  // Inverse of the rounding quantizer: scale by two, LSB always zero.
  function automatic logic [OUT_W-1:0] dequant_word(input logic [IN_W-1:0] q);
    return {q, 1'b0};
  endfunction

endpackage

// File: rtl/dequant_skid.sv
// Output register plus one skid entry with ready/valid on both sides; keeps
// full throughput under backpressure while in_ready stays registered.
module dequant_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_rec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_rec
);

  logic         skid_valid;
  logic [W-1:0] skid_rec;
  logic         accept;
  logic         drain;
  logic         out_valid_nxt;
  logic         skid_valid_nxt;
  logic         load_from_in;
  logic         load_from_skid;
  logic         load_skid;

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  // Routing decision for the next cycle; clr discards any incoming row.
  always_comb begin
    out_valid_nxt  = out_valid;
    skid_valid_nxt = skid_valid;
    load_from_in   = 1'b0;
    load_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (clr) begin
      out_valid_nxt  = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (drain) begin
      if (skid_valid) begin
        load_from_skid = 1'b1;
        out_valid_nxt  = 1'b1;
        skid_valid_nxt = 1'b0;
      end else if (accept) begin
        load_from_in  = 1'b1;
        out_valid_nxt = 1'b1;
      end else begin
        out_valid_nxt = 1'b0;
      end
    end else if (!out_valid) begin
      if (accept) begin
        load_from_in  = 1'b1;
        out_valid_nxt = 1'b1;
      end else begin
        out_valid_nxt = 1'b0;
      end
    end else begin
      if (accept) begin
        load_skid      = 1'b1;
        skid_valid_nxt = 1'b1;
      end else begin
        skid_valid_nxt = skid_valid;
      end
    end
  end

  // Storage state; in_ready is derived from the next skid occupancy.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
      out_rec    <= '0;
      skid_rec   <= '0;
    end else begin
      out_valid  <= out_valid_nxt;
      skid_valid <= skid_valid_nxt;
      in_ready   <= !skid_valid_nxt;
      if (load_from_skid) begin
        out_rec <= skid_rec;
      end else if (load_from_in) begin
        out_rec <= in_rec;
      end
      if (load_skid) begin
        skid_rec <= in_rec;
      end
    end
  end

endmodule

// File: rtl/dequant.sv
// Row dequantizer: scales eight coefficients by two, tags each row with its
// position in the block and streams rows out through a skid pipeline.
module dequant
  import dequant_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic             soft_clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data_01,
  input  logic [IN_W-1:0]  in_data_02,
  input  logic [IN_W-1:0]  in_data_03,
  input  logic [IN_W-1:0]  in_data_04,
  input  logic [IN_W-1:0]  in_data_05,
  input  logic [IN_W-1:0]  in_data_06,
  input  logic [IN_W-1:0]  in_data_07,
  input  logic [IN_W-1:0]  in_data_08,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data_01,
  output logic [OUT_W-1:0] out_data_02,
  output logic [OUT_W-1:0] out_data_03,
  output logic [OUT_W-1:0] out_data_04,
  output logic [OUT_W-1:0] out_data_05,
  output logic [OUT_W-1:0] out_data_06,
  output logic [OUT_W-1:0] out_data_07,
  output logic [OUT_W-1:0] out_data_08,
  output logic [ROW_W-1:0] out_row,
  output logic             out_last,
  output logic             block_done
);

  logic [LANES-1:0][IN_W-1:0] in_words;
  row_rec_t                   in_rec;
  row_rec_t                   out_rec;
  logic [ROW_W-1:0]           row_cnt;
  logic                       accept;
  logic                       out_hs;

  assign in_words = {in_data_08, in_data_07, in_data_06, in_data_05,
                     in_data_04, in_data_03, in_data_02, in_data_01};

  // Every lane is scaled independently by the shared helper.
  always_comb begin
    in_rec.row = row_cnt;
    for (int i = 0; i < LANES; i++) begin
      in_rec.data[i] = dequant_word(in_words[i]);
    end
  end

  dequant_skid #(.W(REC_W)) u_skid (
    .clk       (clk),
    .nrst      (nrst),
    .clr       (soft_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rec    (in_rec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rec   (out_rec)
  );

  assign accept = in_valid && in_ready && !soft_clr;
  assign out_hs = out_valid && out_ready;

  // Row counter advances only on rows that actually enter the pipeline.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      row_cnt <= '0;
    end else if (soft_clr) begin
      row_cnt <= '0;
    end else if (accept) begin
      row_cnt <= (row_cnt == ROW_W'(ROWS - 1)) ? '0 : row_cnt + ROW_W'(1);
    end
  end

  // Block-complete pulse follows the downstream handshake of the last row.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      block_done <= 1'b0;
    end else begin
      block_done <= out_hs && out_last && !soft_clr;
    end
  end

  assign out_data_01 = out_rec.data[0];
  assign out_data_02 = out_rec.data[1];
  assign out_data_03 = out_rec.data[2];
  assign out_data_04 = out_rec.data[3];
  assign out_data_05 = out_rec.data[4];
  assign out_data_06 = out_rec.data[5];
  assign out_data_07 = out_rec.data[6];
  assign out_data_08 = out_rec.data[7];
  assign out_row     = out_rec.row;
  assign out_last    = (out_rec.row == ROW_W'(ROWS - 1));

endmodule

// File: tb/tb_dequant.sv
// Directed bench for dequant: a scoreboard queue of expected rows is compared
// against the presented output row every cycle.
module tb_dequant;

  typedef struct packed {
    logic [7:0][8:0] d;
    logic [2:0]      row;
  } exp_t;

  logic       clk;
  logic       nrst;
  logic       soft_clr;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din [8];
  logic       out_valid;
  logic       out_ready;
  logic [8:0] dout [8];
  logic [2:0] out_row;
  logic       out_last;
  logic       block_done;

  exp_t       q[$];
  logic [2:0] exp_row;
  logic       exp_done;
  int         n_assert;
  int         n_fail;
  int         done_cnt;

  dequant dut (
    .clk        (clk),
    .nrst       (nrst),
    .soft_clr   (soft_clr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data_01 (din[0]),
    .in_data_02 (din[1]),
    .in_data_03 (din[2]),
    .in_data_04 (din[3]),
    .in_data_05 (din[4]),
    .in_data_06 (din[5]),
    .in_data_07 (din[6]),
    .in_data_08 (din[7]),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data_01(dout[0]),
    .out_data_02(dout[1]),
    .out_data_03(dout[2]),
    .out_data_04(dout[3]),
    .out_data_05(dout[4]),
    .out_data_06(dout[5]),
    .out_data_07(dout[6]),
    .out_data_08(dout[7]),
    .out_row    (out_row),
    .out_last   (out_last),
    .block_done (block_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_row(input logic [7:0] base, input logic [7:0] stride);
    for (int i = 0; i < 8; i++) din[i] = base + stride * 8'(i);
  endtask

  // Called at a negedge with inputs already driven; ends at the next negedge.
  task automatic step();
    exp_t e;
    logic acc;
    logic drn;
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    if (q.size() != 0) begin
      for (int i = 0; i < 8; i++) chk($sformatf("lane%0d", i), {23'd0, dout[i]}, {23'd0, q[0].d[i]});
      chk("out_row", {29'd0, out_row}, {29'd0, q[0].row});
      chk("out_last", {31'd0, out_last}, {31'd0, q[0].row == 3'd7});
    end
    acc = in_valid && (q.size() < 2);
    drn = out_ready && (q.size() != 0);
    exp_done = drn && (q[0].row == 3'd7) && !soft_clr;
    if (drn) void'(q.pop_front());
    if (soft_clr) begin
      q.delete();
      exp_row = 3'd0;
    end else if (acc) begin
      for (int i = 0; i < 8; i++) e.d[i] = {din[i], 1'b0};
      e.row = exp_row;
      q.push_back(e);
      exp_row = exp_row + 3'd1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("block_done", {31'd0, block_done}, {31'd0, exp_done});
    if (block_done) done_cnt++;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() != 0; k++) step();
    chk("drained", q.size(), 32'd0);
  endtask

  initial begin
    n_assert = 0; n_fail = 0; done_cnt = 0;
    exp_row = 3'd0; exp_done = 1'b0;
    nrst = 1'b0; soft_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_row(8'h00, 8'h00);
    @(negedge clk);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst out_data", {23'd0, dout[0]}, 32'd0);
    chk("rst out_row", {29'd0, out_row}, 32'd0);
    chk("rst out_last", {31'd0, out_last}, 32'd0);
    chk("rst block_done", {31'd0, block_done}, 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // Full block of 8'hFF at full throughput.
    out_ready = 1'b1; in_valid = 1'b1; set_row(8'hFF, 8'h00);
    done_cnt = 0;
    for (int r = 0; r < 8; r++) step();
    drain();
    chk("block1 done count", done_cnt, 32'd1);

    // Lane boundary values.
    in_valid = 1'b1;
    din[0] = 8'h00; din[1] = 8'h01; din[2] = 8'h7F; din[3] = 8'h80;
    din[4] = 8'hFE; din[5] = 8'hFF; din[6] = 8'h55; din[7] = 8'hAA;
    step();
    in_valid = 1'b0;
    chk("lane 7F", {23'd0, dout[2]}, 32'h0FE);
    chk("lane AA", {23'd0, dout[7]}, 32'h154);
    drain();

    // Backpressure: 3 stalled cycles with input pending, then release.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      set_row(8'(8'h10 * r), 8'h03);
      step();
    end
    chk("bp queued", q.size(), 32'd2);
    out_ready = 1'b1;
    set_row(8'h40, 8'h05);
    step();
    in_valid = 1'b0;
    drain();

    // soft_clr with the skid full and a row pending.
    out_ready = 1'b0; in_valid = 1'b1;
    set_row(8'h21, 8'h01); step();
    set_row(8'h31, 8'h01); step();
    soft_clr = 1'b1; set_row(8'h41, 8'h01); step();
    soft_clr = 1'b0; in_valid = 1'b0;
    chk("clr out_valid", {31'd0, out_valid}, 32'd0);
    chk("clr in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; set_row(8'h51, 8'h02); step();
    in_valid = 1'b0;
    chk("clr first row", {29'd0, out_row}, 32'd0);
    drain();

    // Nine consecutive rows wrap the counter; one block_done.
    done_cnt = 0; in_valid = 1'b1;
    for (int r = 0; r < 9; r++) begin
      set_row(8'(r * 7 + 1), 8'h0B);
      step();
    end
    drain();
    chk("wrap done count", done_cnt, 32'd1);

    // Asynchronous reset mid-block with a row presented.
    set_row(8'h66, 8'h01); in_valid = 1'b1; step(); step();
    in_valid = 1'b0;
    #2 nrst = 1'b0;
    #1;
    chk("arst out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst out_data", {23'd0, dout[3]}, 32'd0);
    chk("arst out_row", {29'd0, out_row}, 32'd0);
    chk("arst in_ready", {31'd0, in_ready}, 32'd1);
    q.delete(); exp_row = 3'd0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; set_row(8'h70, 8'h01); step();
    in_valid = 1'b0;
    chk("arst first row", {29'd0, out_row}, 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
